// File: rtl/pe_bitfusion_acc_pkg.sv
// Shared mode encodings, FSM state type and dot-width helper for the bit-fusion accumulating PE.
package pe_bitfusion_acc_pkg;

    localparam logic PE_MODE_XNOR = 1'b0;
    localparam logic PE_MODE_2B   = 1'b1;

    typedef enum logic [1:0] {
        StAcc   = 2'd0,
        StDrain = 2'd1,
        StOut   = 2'd2
    } pe_state_e;

    // Lossless signed width of a LANES-wide sum of lane products (|product| <= 6).
    function automatic int unsigned dot_width(input int unsigned lanes);
        return $clog2(lanes) + 4;
    endfunction

endpackage

// File: rtl/pe_bitfusion_acc_if.sv
// Beat-input and result-output handshake bundle for pe_bitfusion_acc.
interface pe_bitfusion_acc_if #(
    parameter int unsigned LANES    = 16,
    parameter int unsigned ACC_BITS = 24,
    parameter int unsigned SHIFT_W  = 4,
    parameter int unsigned CNT_BITS = 8
);
    logic                       i_valid;
    logic                       o_ready;
    logic                       i_mode;
    logic                       i_sign_a;
    logic [2*LANES-1:0]         i_act;
    logic [2*LANES-1:0]         i_weight;
    logic [SHIFT_W-1:0]         i_shift;
    logic                       i_last;
    logic                       o_valid;
    logic                       i_ready;
    logic signed [ACC_BITS-1:0] o_psum;
    logic [CNT_BITS-1:0]        o_count;

    modport master (
        output i_valid, i_mode, i_sign_a, i_act, i_weight, i_shift, i_last, i_ready,
        input  o_ready, o_valid, o_psum, o_count
    );

    modport slave (
        input  i_valid, i_mode, i_sign_a, i_act, i_weight, i_shift, i_last, i_ready,
        output o_ready, o_valid, o_psum, o_count
    );
endinterface

// File: rtl/pe_bitfusion_acc_lane_dot.sv
// Combinational lane products (2b x 2b or 1b XNOR) summed into a lossless signed dot product.
module pe_bitfusion_acc_lane_dot
    import pe_bitfusion_acc_pkg::*;
#(
    parameter int unsigned LANES = 16
) (
    input  logic                                  i_mode,
    input  logic                                  i_sign_a,
    input  logic [2*LANES-1:0]                    i_act,
    input  logic [2*LANES-1:0]                    i_weight,
    output logic signed [dot_width(LANES)-1:0]    o_dot
);
    localparam int unsigned DotW = dot_width(LANES);

    logic signed [5:0] a_ext;
    logic signed [5:0] w_ext;
    logic signed [5:0] prod;

    always_comb begin
        o_dot = '0;
        a_ext = '0;
        w_ext = '0;
        prod  = '0;
        for (int k = 0; k < LANES; k++) begin
            a_ext = {{4{i_sign_a & i_act[2*k+1]}}, i_act[2*k +: 2]};
            w_ext = {{4{i_weight[2*k+1]}}, i_weight[2*k +: 2]};
            if (i_mode == PE_MODE_2B) begin
                prod = a_ext * w_ext;
            end else begin
                // XNOR of the bit0 encodings: equal bits -> +1, different -> -1.
                prod = (i_act[2*k] == i_weight[2*k]) ? 6'sd1 : -6'sd1;
            end
            o_dot = o_dot + DotW'(prod);
        end
    end

endmodule

// File: rtl/pe_bitfusion_acc.sv
// Precision-configurable PE: per-beat dot product, shift and multi-beat accumulate with held result.
// Define PE_ACC_SAT_EN for sticky saturating accumulation; otherwise the accumulator wraps.
module pe_bitfusion_acc
    import pe_bitfusion_acc_pkg::*;
#(
    parameter int unsigned LANES    = 16,
    parameter int unsigned ACC_BITS = 24,
    parameter int unsigned SHIFT_W  = 4,
    parameter int unsigned CNT_BITS = 8
) (
    input logic               clk,
    input logic               rst_n,
    pe_bitfusion_acc_if.slave bus
);
    localparam int unsigned DotW  = dot_width(LANES);
    localparam int unsigned TermW = DotW + (2 ** SHIFT_W) - 1;
    localparam int unsigned SumW  = ((TermW > ACC_BITS) ? TermW : ACC_BITS) + 1;

    pe_state_e                  state_q, state_d;
    logic                       s1_valid_q, s1_valid_d;
    logic signed [DotW-1:0]     dot, dot_q, dot_d;
    logic [SHIFT_W-1:0]         shift_q, shift_d;
    logic                       last_q, last_d;
    logic signed [ACC_BITS-1:0] acc_q, acc_d, acc_new;
    logic signed [ACC_BITS-1:0] psum_q, psum_d;
    logic [CNT_BITS-1:0]        cnt_q, cnt_d, cnt_inc;
    logic [CNT_BITS-1:0]        count_q, count_d;
    logic                       valid_q, valid_d;
    logic signed [SumW-1:0]     term, sum;
    logic                       accept;

    pe_bitfusion_acc_lane_dot #(
        .LANES (LANES)
    ) u_lane_dot (
        .i_mode   (bus.i_mode),
        .i_sign_a (bus.i_sign_a),
        .i_act    (bus.i_act),
        .i_weight (bus.i_weight),
        .o_dot    (dot)
    );

    assign accept = bus.i_valid && bus.o_ready;
    // Wide enough that neither the shifted term nor acc + term can overflow before wrap/clamp.
    assign term   = SumW'(dot_q) <<< shift_q;
    assign sum    = SumW'(acc_q) + term;

`ifdef PE_ACC_SAT_EN
    localparam logic signed [SumW-1:0] AccMax = {{(SumW-ACC_BITS+1){1'b0}}, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [SumW-1:0] AccMin = ~AccMax;

    logic sat_q, sat_d, sat_new;

    // Once railed, the accumulator is frozen until the sequence ends.
    always_comb begin
        acc_new = sum[ACC_BITS-1:0];
        sat_new = sat_q;
        if (sat_q) begin
            acc_new = acc_q;
        end else if (sum > AccMax) begin
            acc_new = AccMax[ACC_BITS-1:0];
            sat_new = 1'b1;
        end else if (sum < AccMin) begin
            acc_new = AccMin[ACC_BITS-1:0];
            sat_new = 1'b1;
        end
    end
`else
    logic unused_sum_hi;
    assign acc_new       = sum[ACC_BITS-1:0];
    assign unused_sum_hi = ^sum[SumW-1:ACC_BITS];
`endif

    always_comb begin
        state_d    = state_q;
        s1_valid_d = accept;
        dot_d      = dot_q;
        shift_d    = shift_q;
        last_d     = last_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        psum_d     = psum_q;
        count_d    = count_q;
        valid_d    = valid_q;
        cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
`ifdef PE_ACC_SAT_EN
        sat_d      = sat_q;
`endif

        if (accept) begin
            dot_d   = dot;
            shift_d = bus.i_shift;
            last_d  = bus.i_last;
        end

        if (s1_valid_q) begin
            if (last_q) begin
                psum_d  = acc_new;
                count_d = cnt_inc;
                valid_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
            end else begin
                acc_d = acc_new;
                cnt_d = cnt_inc;
            end
`ifdef PE_ACC_SAT_EN
            sat_d = last_q ? 1'b0 : sat_new;
`endif
        end

        unique case (state_q)
            StAcc:   if (accept && bus.i_last) state_d = StDrain;
            StDrain: if (s1_valid_q) state_d = StOut;
            StOut: begin
                if (bus.i_ready) begin
                    state_d = StAcc;
                    valid_d = 1'b0;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StAcc;
            s1_valid_q <= 1'b0;
            dot_q      <= '0;
            shift_q    <= '0;
            last_q     <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            psum_q     <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
`ifdef PE_ACC_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            dot_q      <= dot_d;
            shift_q    <= shift_d;
            last_q     <= last_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            psum_q     <= psum_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
`ifdef PE_ACC_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    assign bus.o_ready = (state_q == StAcc);
    assign bus.o_valid = valid_q;
    assign bus.o_psum  = psum_q;
    assign bus.o_count = count_q;

endmodule

// File: tb/tb_pe_bitfusion_acc.sv
// Directed + randomized bench for pe_bitfusion_acc against an arithmetic sequence model.
module tb_pe_bitfusion_acc;
    localparam int unsigned LANES    = 16;
    localparam int unsigned SHIFT_W  = 4;
    localparam int unsigned CNT_BITS = 8;

    typedef struct {
        logic               mode;
        logic               sign_a;
        logic [2*LANES-1:0] act;
        logic [2*LANES-1:0] w;
        logic [SHIFT_W-1:0] shift;
    } beat_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     n_checks = 0;
    int     n_fail = 0;
    beat_t  beats[$];

    pe_bitfusion_acc_if #(.LANES(LANES), .ACC_BITS(24), .SHIFT_W(SHIFT_W), .CNT_BITS(CNT_BITS)) a_if ();
    pe_bitfusion_acc_if #(.LANES(LANES), .ACC_BITS(8), .SHIFT_W(SHIFT_W), .CNT_BITS(CNT_BITS)) b_if ();

    pe_bitfusion_acc #(.LANES(LANES), .ACC_BITS(24), .SHIFT_W(SHIFT_W), .CNT_BITS(CNT_BITS)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    pe_bitfusion_acc #(.LANES(LANES), .ACC_BITS(8), .SHIFT_W(SHIFT_W), .CNT_BITS(CNT_BITS)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [63:0] obs_psum(input bit on_b);
        return on_b ? 64'($signed(b_if.o_psum)) : 64'($signed(a_if.o_psum));
    endfunction

    function automatic logic signed [63:0] obs_count(input bit on_b);
        return on_b ? 64'(b_if.o_count) : 64'(a_if.o_count);
    endfunction

    function automatic logic signed [63:0] obs_valid(input bit on_b);
        return on_b ? 64'(b_if.o_valid) : 64'(a_if.o_valid);
    endfunction

    function automatic logic signed [63:0] obs_ready(input bit on_b);
        return on_b ? 64'(b_if.o_ready) : 64'(a_if.o_ready);
    endfunction

    // Signed lane value times signed weight, or +/-1 agreement count, summed over lanes.
    function automatic longint model_dot(input beat_t bt);
        longint s;
        logic [1:0] ab, wb;
        int av, wv;
        s = 0;
        for (int k = 0; k < int'(LANES); k++) begin
            ab = bt.act[2*k +: 2];
            wb = bt.w[2*k +: 2];
            if (bt.mode) begin
                av = int'(ab);
                if (bt.sign_a && ab[1]) av -= 4;
                wv = int'(wb);
                if (wb[1]) wv -= 4;
                s += longint'(av * wv);
            end else begin
                s += (ab[0] == wb[0]) ? 1 : -1;
            end
        end
        return s;
    endfunction

`ifndef PE_ACC_SAT_EN
    function automatic longint wrap(input longint v, input int bits);
        longint m, r;
        m = longint'(1) <<< bits;
        r = v & (m - 1);
        if (r >= m / 2) r -= m;
        return r;
    endfunction
`endif

    function automatic logic signed [63:0] model_psum(input int acc_bits);
        longint acc, term;
`ifdef PE_ACC_SAT_EN
        longint hi, lo;
        bit railed;
        railed = 1'b0;
        hi = (longint'(1) <<< (acc_bits - 1)) - 1;
        lo = -hi - 1;
`endif
        acc = 0;
        foreach (beats[i]) begin
            term = model_dot(beats[i]) * (longint'(1) <<< beats[i].shift);
`ifdef PE_ACC_SAT_EN
            if (!railed) begin
                acc += term;
                if (acc > hi) begin
                    acc = hi;
                    railed = 1'b1;
                end else if (acc < lo) begin
                    acc = lo;
                    railed = 1'b1;
                end
            end
`else
            acc = wrap(acc + term, acc_bits);
`endif
        end
        return acc;
    endfunction

    function automatic beat_t mk_beat(input logic mode, input logic sign_a, input logic [31:0] act,
                                      input logic [31:0] w, input int shift);
        beat_t bt;
        bt.mode   = mode;
        bt.sign_a = sign_a;
        bt.act    = act;
        bt.w      = w;
        bt.shift  = SHIFT_W'(shift);
        return bt;
    endfunction

    function automatic beat_t rand_beat();
        return mk_beat(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                       int'($urandom_range(0, 15)));
    endfunction

    task automatic drive(input bit on_b, input bit vld, input bit last, input beat_t bt);
        a_if.i_valid  = vld && !on_b;
        b_if.i_valid  = vld && on_b;
        a_if.i_mode   = bt.mode;    b_if.i_mode   = bt.mode;
        a_if.i_sign_a = bt.sign_a;  b_if.i_sign_a = bt.sign_a;
        a_if.i_act    = bt.act;     b_if.i_act    = bt.act;
        a_if.i_weight = bt.w;       b_if.i_weight = bt.w;
        a_if.i_shift  = bt.shift;   b_if.i_shift  = bt.shift;
        a_if.i_last   = last;       b_if.i_last   = last;
    endtask

    // Streams the queued beats back to back, checks result timing, then consumes after `stall`.
    task automatic play(input bit on_b, input int stall);
        logic signed [63:0] exp_psum, exp_cnt;
        beat_t idle;
        idle = mk_beat(1'b0, 1'b0, '0, '0, 0);
        exp_psum = model_psum(on_b ? 8 : 24);
        exp_cnt  = (beats.size() > 255) ? 255 : beats.size();
        foreach (beats[i]) begin
            @(negedge clk);
            if (i == 0) check("ready_at_start", obs_ready(on_b), 1);
            drive(on_b, 1'b1, (i == beats.size() - 1), beats[i]);
        end
        @(negedge clk);
        drive(on_b, 1'b0, 1'b0, idle);
        check("valid_during_drain", obs_valid(on_b), 0);
        check("ready_during_drain", obs_ready(on_b), 0);
        @(negedge clk);
        check("valid_result", obs_valid(on_b), 1);
        check("psum", obs_psum(on_b), exp_psum);
        check("count", obs_count(on_b), exp_cnt);
        check("ready_while_out", obs_ready(on_b), 0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check("valid_held", obs_valid(on_b), 1);
            check("psum_held", obs_psum(on_b), exp_psum);
            check("count_held", obs_count(on_b), exp_cnt);
            check("ready_held_low", obs_ready(on_b), 0);
        end
        a_if.i_ready = 1'b1;
        b_if.i_ready = 1'b1;
        @(negedge clk);
        a_if.i_ready = 1'b0;
        b_if.i_ready = 1'b0;
        check("valid_after_consume", obs_valid(on_b), 0);
        check("ready_after_consume", obs_ready(on_b), 1);
    endtask

    initial begin
        beat_t idle;
        idle = mk_beat(1'b0, 1'b0, '0, '0, 0);
        drive(1'b0, 1'b0, 1'b0, idle);
        a_if.i_ready = 1'b0;
        b_if.i_ready = 1'b0;

        #12;
        check("rst_valid", obs_valid(0), 0);
        check("rst_ready", obs_ready(0), 1);
        check("rst_psum", obs_psum(0), 0);
        check("rst_count", obs_count(0), 0);
        check("rst_b_ready", obs_ready(1), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Unsigned 3 x signed -2 on all lanes.
        beats.delete();
        beats.push_back(mk_beat(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 0));
        play(0, 0);

        // XNOR: half agree, then all agree.
        beats.delete();
        beats.push_back(mk_beat(1'b0, 1'b0, 32'h5555_5555, 32'h0000_5555, 0));
        play(0, 0);
        beats.delete();
        beats.push_back(mk_beat(1'b0, 1'b1, 32'h5555_5555, 32'h5555_5555, 0));
        play(0, 0);

        // Bit-serial significance: shifts 0,2,4,6.
        beats.delete();
        for (int i = 0; i < 4; i++)
            beats.push_back(mk_beat(1'b1, 1'b0, 32'h5555_5555, 32'h5555_5555, 2 * i));
        play(0, 0);

        // Backpressure, then an immediate fresh sequence.
        beats.delete();
        for (int i = 0; i < 3; i++) beats.push_back(rand_beat());
        play(0, 5);
        beats.delete();
        beats.push_back(rand_beat());
        play(0, 0);

        // 8-bit accumulator overflow: +128 terms.
        beats.delete();
        for (int i = 0; i < 3; i++)
            beats.push_back(mk_beat(1'b1, 1'b1, 32'h5555_5555, 32'h5555_5555, 3));
        play(1, 1);
        beats.delete();
        for (int i = 0; i < 4; i++)
            beats.push_back(mk_beat(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 1));
        play(1, 0);

        // Mixed-mode random sequences on either instance.
        for (int n = 0; n < 8; n++) begin
            beats.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) beats.push_back(rand_beat());
            play(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        // Beat counter saturation.
        beats.delete();
        for (int i = 0; i < 260; i++)
            beats.push_back(mk_beat(1'b0, 1'b0, $urandom, $urandom, 0));
        play(0, 0);

        // Reset with two beats in flight.
        beats.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, rand_beat());
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, idle);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", obs_valid(0), 0);
        check("midrst_ready", obs_ready(0), 1);
        check("midrst_psum", obs_psum(0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) beats.push_back(rand_beat());
        play(0, 0);

        // Reset discards a pending result.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, mk_beat(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h5555_5555, 2));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, idle);
        @(negedge clk);
        check("pend_valid", obs_valid(0), 1);
        rst_n = 1'b0;
        #1;
        check("pend_rst_valid", obs_valid(0), 0);
        check("pend_rst_count", obs_count(0), 0);
        check("pend_rst_ready", obs_ready(0), 1);
        @(negedge clk);
        rst_n = 1'b1;
        beats.delete();
        for (int i = 0; i < 2; i++) beats.push_back(rand_beat());
        play(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
